// File: rtl/cpu_pkg.sv
// Shared CPU constants: PC width, program-state encoding, next-PC select and entry table.
package cpu_pkg;

  localparam int unsigned PC_W      = 10;
  localparam int unsigned NUM_PROGS = 3;
  localparam int unsigned IDX_W     = 2;

  typedef enum logic [1:0] {
    PC_IDLE  = 2'd0,
    PC_ARMED = 2'd1,
    PC_RUN   = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_LOAD   = 3'd1,
    SEL_JUMP   = 3'd2,
    SEL_BRANCH = 3'd3,
    SEL_INC    = 3'd4
  } pc_sel_e;

  localparam logic [PC_W-1:0] PROG_ENTRY [NUM_PROGS] = '{10'h004, 10'h100, 10'h200};

  // Entry address for a program index; indices past the table map to address 0.
  function automatic logic [PC_W-1:0] prog_entry_at(input logic [IDX_W-1:0] idx);
    prog_entry_at = '0;
    for (int unsigned i = 0; i < NUM_PROGS; i++) begin
      if (idx == IDX_W'(i)) prog_entry_at = PROG_ENTRY[i];
    end
  endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC mux: hold, entry load, absolute jump, relative branch, increment.
module pc_next
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = cpu_pkg::PC_W
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] target,
  input  logic [PC_W-1:0] entry,
  input  pc_sel_e         sel,
  output logic [PC_W-1:0] next_pc_c
);

  // Sums are PC_W wide so they wrap naturally; a two's-complement offset needs no sign extension.
  always_comb begin
    next_pc_c = pc;
    unique case (sel)
      SEL_HOLD:   next_pc_c = pc;
      SEL_LOAD:   next_pc_c = entry;
      SEL_JUMP:   next_pc_c = target;
      SEL_BRANCH: next_pc_c = pc + target;
      SEL_INC:    next_pc_c = pc + PC_W'(1);
      default:    next_pc_c = pc;
    endcase
  end

endmodule

// File: rtl/program_counter.sv
// Program counter: launches programs from the entry table on Start falling edge, then
// increments, jumps or branches each cycle. ProgCtr is a pure register output.
module program_counter #(
  parameter int unsigned PC_W      = cpu_pkg::PC_W,
  parameter int unsigned NUM_PROGS = cpu_pkg::NUM_PROGS
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Jump,
  input  logic            BOE,
  input  logic            IsEqual,
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] ProgCtr
);

  import cpu_pkg::*;

  pc_state_e              state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [IDX_W-1:0]       prog_idx_q, prog_idx_d;
  pc_sel_e                sel_c;
  logic [PC_W-1:0]        entry_c;

  assign entry_c = PC_W'(prog_entry_at(prog_idx_q));

  // Next-state, program index and PC-select decode.
  always_comb begin
    state_d    = state_q;
    prog_idx_d = prog_idx_q;
    sel_c      = SEL_HOLD;
    unique case (state_q)
      PC_IDLE: begin
        if (Start) state_d = PC_ARMED;
      end
      PC_ARMED: begin
        if (!Start) begin
          sel_c      = SEL_LOAD;
          state_d    = PC_RUN;
          prog_idx_d = (prog_idx_q == IDX_W'(NUM_PROGS - 1)) ? '0 : prog_idx_q + IDX_W'(1);
        end
      end
      PC_RUN: begin
        if (Start)                 state_d = PC_ARMED;
        else if (Jump)             sel_c   = SEL_JUMP;
        else if (BOE && IsEqual)   sel_c   = SEL_BRANCH;
        else                       sel_c   = SEL_INC;
      end
      default: state_d = PC_IDLE;
    endcase
  end

  pc_next #(.PC_W(PC_W)) u_pc_next (
    .pc        (pc_q),
    .target    (Target),
    .entry     (entry_c),
    .sel       (sel_c),
    .next_pc_c (pc_d)
  );

  // State, PC and program-index registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= PC_IDLE;
      pc_q       <= '0;
      prog_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      prog_idx_q <= prog_idx_d;
    end
  end

  assign ProgCtr = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: vector table plus hand-written sequences,
// expected PCs queued on drive and popped after the clock edge.
module tb_program_counter;

  localparam int unsigned PC_W = 10;

  logic            Clk = 1'b0;
  logic            Reset, Start, Jump, BOE, IsEqual;
  logic [PC_W-1:0] Target;
  logic [PC_W-1:0] ProgCtr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic            rst;
    logic            start;
    logic            jump;
    logic            boe;
    logic            eq;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] exp_pc;
    string           name;
  } vec_t;

  typedef struct {
    logic [PC_W-1:0] pc;
    string           name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  program_counter #(.PC_W(PC_W), .NUM_PROGS(3)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .Jump    (Jump),
    .BOE     (BOE),
    .IsEqual (IsEqual),
    .Target  (Target),
    .ProgCtr (ProgCtr)
  );

  always #5 Clk = ~Clk;

  task automatic add_vec(input logic rst, input logic start, input logic jump, input logic boe,
                         input logic eq, input logic [PC_W-1:0] target,
                         input logic [PC_W-1:0] exp_pc, input string name);
    vec_t v;
    v.rst = rst; v.start = start; v.jump = jump; v.boe = boe; v.eq = eq;
    v.target = target; v.exp_pc = exp_pc; v.name = name;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, queue the expected PC, then check it after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    Reset = v.rst; Start = v.start; Jump = v.jump; BOE = v.boe; IsEqual = v.eq; Target = v.target;
    e.pc = v.exp_pc; e.name = v.name;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    got = sb.pop_front();
    checks++;
    if (ProgCtr !== got.pc) begin
      errors++;
      $display("FAIL %s: ProgCtr=0x%03h expected=0x%03h", got.name, ProgCtr, got.pc);
    end
  endtask

  initial begin
    vec_t v;
    logic [PC_W-1:0] model_pc;
    Reset = 1'b0; Start = 1'b0; Jump = 1'b0; BOE = 1'b0; IsEqual = 1'b0; Target = '0;

    //       rst start jump boe eq target   exp      name
    add_vec(1, 0, 0, 0, 0, 10'h000, 10'h000, "reset");
    add_vec(0, 0, 0, 0, 0, 10'h000, 10'h000, "idle_hold");
    add_vec(0, 0, 1, 1, 1, 10'h055, 10'h000, "idle_ignores_jump");
    add_vec(0, 1, 0, 0, 0, 10'h000, 10'h000, "start_high_hold");
    add_vec(0, 0, 0, 0, 0, 10'h000, 10'h004, "launch_prog0");
    add_vec(0, 0, 0, 0, 0, 10'h000, 10'h005, "inc_after_launch");
    add_vec(0, 0, 1, 0, 0, 10'h00A, 10'h00A, "jump_abs");
    add_vec(0, 0, 0, 1, 1, 10'h00A, 10'h014, "boe_taken");
    add_vec(0, 0, 0, 1, 0, 10'h00A, 10'h015, "boe_not_taken");
    add_vec(0, 0, 1, 1, 1, 10'h007, 10'h007, "jump_beats_boe");
    add_vec(0, 0, 0, 1, 1, 10'h3FE, 10'h005, "boe_negative");
    add_vec(0, 1, 1, 0, 0, 10'h0AA, 10'h005, "run_start_hold");
    add_vec(0, 1, 1, 1, 1, 10'h0AA, 10'h005, "armed_hold_long");
    add_vec(0, 1, 0, 0, 0, 10'h000, 10'h005, "armed_hold_long2");
    add_vec(0, 0, 0, 0, 0, 10'h000, 10'h100, "launch_prog1");
    add_vec(0, 0, 0, 0, 0, 10'h000, 10'h101, "inc_prog1");
    add_vec(0, 1, 0, 0, 0, 10'h000, 10'h101, "pulse3_hold");
    add_vec(0, 0, 0, 0, 0, 10'h000, 10'h200, "launch_prog2");
    add_vec(0, 1, 0, 0, 0, 10'h000, 10'h200, "pulse4_hold");
    add_vec(0, 0, 0, 0, 0, 10'h000, 10'h004, "launch_wrap_prog0");
    add_vec(0, 0, 1, 0, 0, 10'h3FF, 10'h3FF, "jump_top");
    add_vec(0, 0, 0, 0, 0, 10'h000, 10'h000, "inc_wrap");
    add_vec(0, 0, 1, 0, 0, 10'h123, 10'h123, "jump_123");
    add_vec(1, 1, 1, 1, 1, 10'h0FF, 10'h000, "reset_mid_run");
    add_vec(0, 0, 1, 1, 1, 10'h055, 10'h000, "idle_after_reset");
    add_vec(0, 1, 0, 0, 0, 10'h000, 10'h000, "pulse_after_reset");
    add_vec(0, 0, 0, 0, 0, 10'h000, 10'h004, "relaunch_prog0");
    add_vec(0, 0, 0, 1, 1, 10'h3FF, 10'h003, "boe_minus_one");
    add_vec(0, 0, 0, 1, 1, 10'h3FE, 10'h001, "boe_minus_two");
    add_vec(0, 0, 0, 1, 1, 10'h3FE, 10'h3FF, "boe_wrap_under");

    foreach (vecs[i]) apply(vecs[i]);

    // Hand sequence: free-running increment across the top of the address space.
    model_pc = 10'h3FF;
    for (int i = 0; i < 6; i++) begin
      model_pc = model_pc + 10'd1;
      v.rst = 0; v.start = 0; v.jump = 0; v.boe = 0; v.eq = 0;
      v.target = 10'($urandom_range(0, 1023));
      v.exp_pc = model_pc; v.name = "free_inc";
      apply(v);
    end

    // Hand sequence: multi-cycle Start in RUN then launch; index after reset advanced once.
    for (int i = 0; i < 4; i++) begin
      v.rst = 0; v.start = 1; v.jump = 0; v.boe = 0; v.eq = 0; v.target = '0;
      v.exp_pc = model_pc; v.name = "long_start_hold";
      apply(v);
    end
    v.start = 0; v.exp_pc = 10'h100; v.name = "launch_after_long_start";
    apply(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
